// File: rtl/pc_unit_if.sv
// Control/status bundle between the fetch controller (master) and pc_unit (slave).
// ADDR_W and RAS_DEPTH must match the parameters of the pc_unit instance this bundle connects to.
interface pc_unit_if #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_underflow;

  modport master (
    output stall, redirect, target, call, ret,
    input  pc, pc_plus, ras_count, ras_underflow
  );

  modport slave (
    input  stall, redirect, target, call, ret,
    output pc, pc_plus, ras_count, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with sequential step, redirect and optional circular return-address stack.
// Define PC_UNIT_RAS_EN to build the stack; otherwise call/ret are ignored and RAS outputs are tied 0.
module pc_unit #(
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int                STEP       = 4,
  parameter int                RAS_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_unit_if.slave    bus
);
  localparam int                CNT_W  = $clog2(RAS_DEPTH) + 1;
  localparam int                SP_W   = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_W = ADDR_W'(STEP);

  logic              w_adv;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_plus;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_adv       = !bus.stall;
  assign w_pc_plus   = r_pc + STEP_W;
  assign bus.pc      = r_pc;
  assign bus.pc_plus = w_pc_plus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_ADDR;
    end else if (w_adv) begin
      r_pc <= w_pc_next;
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  // r_sp is the next free slot; it wraps, so a push when full overwrites the oldest entry.
  logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [SP_W-1:0]   w_sp_top;
  logic [CNT_W-1:0]  r_count;
  logic              r_underflow;
  logic              w_has;
  logic              w_pop;
  logic              w_push;
  logic              w_replace;
  logic              w_under;

  assign w_has     = (r_count != '0);
  assign w_sp_top  = r_sp - SP_W'(1);
  assign w_pop     = bus.ret & ~bus.call & w_has;
  assign w_under   = bus.ret & ~bus.call & ~w_has;
  assign w_push    = bus.call & bus.redirect & ~(bus.ret & w_has);
  assign w_replace = bus.call & bus.redirect & bus.ret & w_has;
  assign w_pc_next = w_pop        ? r_stack[w_sp_top] :
                     bus.redirect ? bus.target        : w_pc_plus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp        <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= w_adv & w_under;
      if (w_adv) begin
        if (w_push) begin
          r_sp <= r_sp + SP_W'(1);
          if (r_count != DEPTH_C) begin
            r_count <= r_count + CNT_W'(1);
          end
        end else if (w_pop) begin
          r_sp    <= w_sp_top;
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  // Storage is never cleared; r_count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_adv && (w_push || w_replace)) begin
      r_stack[w_push ? r_sp : w_sp_top] <= w_pc_plus;
    end
  end

  assign bus.ras_count     = r_count;
  assign bus.ras_underflow = r_underflow;
`else
  assign w_pc_next         = bus.redirect ? bus.target : w_pc_plus;
  assign bus.ras_count     = '0;
  assign bus.ras_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequential stepping, stall, redirect, wrap, RAS push/pop/overflow/underflow, async reset.
// Expectations follow the build: stack behaviour when PC_UNIT_RAS_EN is defined, plain sequencing otherwise.
module tb_pc_unit;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam logic [63:0] WRAP_RESET = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [63:0] exp_pc;

  pc_unit_if #(.ADDR_W(64), .RAS_DEPTH(8)) bus  ();
  pc_unit_if #(.ADDR_W(64), .RAS_DEPTH(8)) bus2 ();

  pc_unit #(.ADDR_W(64), .RESET_ADDR(64'd0), .STEP(4), .RAS_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  pc_unit #(.ADDR_W(64), .RESET_ADDR(WRAP_RESET), .STEP(4), .RAS_DEPTH(8)) dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-12s got=0x%0h", tag, got);
    end else begin
      $display("FAIL %-12s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [63:0] tg,
                       input logic cl, input logic rt);
    bus.stall    = st;
    bus.redirect = rd;
    bus.target   = tg;
    bus.call     = cl;
    bus.ret      = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    drive(0, 0, 64'd0, 0, 0);
    bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.target = '0;
    bus2.call  = 1'b0; bus2.ret      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc",    bus.pc, 64'd0);
    check("rst_plus",  bus.pc_plus, 64'd4);
    check("rst_cnt",   64'(bus.ras_count), 64'd0);
    check("rst_uf",    64'(bus.ras_underflow), 64'd0);
    check("rst2_pc",   bus2.pc, WRAP_RESET);
    check("rst2_plus", bus2.pc_plus, 64'd0);
    #2 rst_n = 1'b1;

    // Sequential stepping, and wrap on the second instance
    step(); check("seq_4", bus.pc, 64'd4);
            check("wrap_pc", bus2.pc, 64'd0);
            check("wrap_uf", 64'(bus2.ras_underflow), 64'd0);
    step(); check("seq_8", bus.pc, 64'd8);
    step(); check("seq_12", bus.pc, 64'd12);
            check("seq_cnt", 64'(bus.ras_count), 64'd0);

    // Redirect and stall
    drive(0, 1, 64'h100, 0, 0); step(); check("redir_100", bus.pc, 64'h100);
    drive(1, 1, 64'h400, 0, 0); step(); check("stall_1", bus.pc, 64'h100);
                                step(); check("stall_2", bus.pc, 64'h100);
    drive(0, 1, 64'h400, 0, 0); step(); check("unstall", bus.pc, 64'h400);
    drive(0, 1, 64'h100, 0, 0); step(); check("redir_back", bus.pc, 64'h100);

    // Call, two advances, return
    drive(0, 1, 64'h800, 1, 0); step(); check("call_pc", bus.pc, 64'h800);
                                        check("call_cnt", 64'(bus.ras_count), RAS ? 64'd1 : 64'd0);
    drive(0, 0, 64'd0, 0, 0);   step(); check("body_804", bus.pc, 64'h804);
                                step(); check("body_808", bus.pc, 64'h808);
                                        check("body_cnt", 64'(bus.ras_count), RAS ? 64'd1 : 64'd0);
    drive(0, 0, 64'd0, 0, 1);   step(); check("ret_pc", bus.pc, RAS ? 64'h104 : 64'h80C);
                                        check("ret_cnt", 64'(bus.ras_count), 64'd0);
                                        check("ret_uf", 64'(bus.ras_underflow), 64'd0);
    exp_pc = bus.pc;

    // Return on an empty stack
    step(); exp_pc += 4;
    check("uf_pc",  bus.pc, exp_pc);
    check("uf_set", 64'(bus.ras_underflow), RAS ? 64'd1 : 64'd0);
    drive(0, 0, 64'd0, 0, 0); step(); exp_pc += 4;
    check("uf_pc2", bus.pc, exp_pc);
    check("uf_clr", 64'(bus.ras_underflow), 64'd0);

    // Nine nested calls overflow the 8-deep stack
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, 64'h1000 * (k + 1), 1, 0);
      step();
      check($sformatf("ncall%0d_pc", k), bus.pc, 64'h1000 * (k + 1));
      check($sformatf("ncall%0d_cnt", k), 64'(bus.ras_count),
            RAS ? 64'((k + 1 > 8) ? 8 : k + 1) : 64'd0);
    end
    exp_pc = 64'h9000;
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 64'd0, 0, 1);
      step();
      if (RAS) exp_pc = (k < 8) ? 64'h1000 * (8 - k) + 64'd4 : exp_pc + 64'd4;
      else     exp_pc = exp_pc + 64'd4;
      check($sformatf("nret%0d_pc", k), bus.pc, exp_pc);
      check($sformatf("nret%0d_uf", k), 64'(bus.ras_underflow), (RAS && k == 8) ? 64'd1 : 64'd0);
    end
    drive(0, 0, 64'd0, 0, 0); step(); exp_pc += 4;
    check("nret_after", bus.pc, exp_pc);
    check("nret_ufclr", 64'(bus.ras_underflow), 64'd0);

    // Simultaneous ret+call+redirect: replace top when non-empty, push when empty
    drive(0, 1, 64'hA000, 1, 0); step(); check("rc_call", bus.pc, 64'hA000);
    drive(0, 1, 64'hB000, 1, 1); step(); check("rc_repl_pc", bus.pc, 64'hB000);
                                         check("rc_repl_cnt", 64'(bus.ras_count), RAS ? 64'd1 : 64'd0);
                                         check("rc_repl_uf", 64'(bus.ras_underflow), 64'd0);
    drive(0, 0, 64'd0, 0, 1);    step(); check("rc_ret1", bus.pc, RAS ? 64'hA004 : 64'hB004);
                                         check("rc_ret1_cnt", 64'(bus.ras_count), 64'd0);
    drive(0, 1, 64'hC000, 1, 1); step(); check("rc_push_pc", bus.pc, 64'hC000);
                                         check("rc_push_cnt", 64'(bus.ras_count), RAS ? 64'd1 : 64'd0);
                                         check("rc_push_uf", 64'(bus.ras_underflow), 64'd0);
    drive(0, 0, 64'd0, 0, 1);    step(); check("rc_ret2", bus.pc, RAS ? 64'hA008 : 64'hC004);
                                         check("rc_ret2_uf", 64'(bus.ras_underflow), 64'd0);

    // Asynchronous reset mid-operation with three entries on the stack
    drive(0, 1, 64'h2000, 1, 0); step();
    drive(0, 1, 64'h3000, 1, 0); step();
    drive(0, 1, 64'h4000, 1, 0); step();
    check("pre_rst_cnt", 64'(bus.ras_count), RAS ? 64'd3 : 64'd0);
    drive(0, 0, 64'd0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc",  bus.pc, 64'd0);
    check("arst_cnt", 64'(bus.ras_count), 64'd0);
    #1 rst_n = 1'b1;
    step(); check("post_rst_pc", bus.pc, 64'd4);
    drive(0, 0, 64'd0, 0, 1);
    step(); check("post_rst_ret", bus.pc, 64'd8);
            check("post_rst_uf", 64'(bus.ras_underflow), RAS ? 64'd1 : 64'd0);
            check("post_rst_cnt", 64'(bus.ras_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
